// File: rtl/oursring_pkg.sv
// Shared definitions for the oursring response path: outstanding-depth default
// and the width rule for master port indices.
package oursring_pkg;

  localparam int OSTD_DEPTH_DEF = 4;

  // Port index width; a single-port ring still needs a 1-bit index.
  function automatic int port_idx_w(input int n_port);
    return (n_port > 1) ? $clog2(n_port) : 1;
  endfunction

endpackage

// File: rtl/oursring_ostd_fifo.sv
// Outstanding-order FIFO of master port indices; head visible 1 cycle after push.
// Push while full is dropped (full from registered count); pop on empty is ignored.
module oursring_ostd_fifo
  import oursring_pkg::*;
#(
  parameter int DEPTH = OSTD_DEPTH_DEF,
  parameter int W     = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic [W-1:0]           push_idx,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so natural pointer overflow is the wrap.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_idx;
  end

endmodule

// File: rtl/oursring_resp_router.sv
// Routes B/R handshakes back to the issuing master in issue order; zero-latency routing.
// Stalls AW/AR grants when an order FIFO is full. Optional OURSRING_RESP_ROUTER_ORPHAN_DROP_EN.
module oursring_resp_router
  import oursring_pkg::*;
#(
  parameter int N_IN_PORT  = 3,
  parameter int OSTD_DEPTH = OSTD_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_IN_PORT-1:0] aw_grant,
  input  logic [N_IN_PORT-1:0] ar_grant,
  output logic                 aw_stall,
  output logic                 ar_stall,
  input  logic                 o_bvalid,
  output logic                 o_bready,
  input  logic                 o_rvalid,
  input  logic                 o_rlast,
  output logic                 o_rready,
  output logic [N_IN_PORT-1:0] i_bvalid,
  input  logic [N_IN_PORT-1:0] i_bready,
  output logic [N_IN_PORT-1:0] i_rvalid,
  input  logic [N_IN_PORT-1:0] i_rready
`ifdef OURSRING_RESP_ROUTER_ORPHAN_DROP_EN
  ,
  output logic [7:0]           orphan_cnt
`endif
);

  localparam int IW = port_idx_w(N_IN_PORT);
  localparam int CW = $clog2(OSTD_DEPTH) + 1;

  logic [IW-1:0] aw_idx, ar_idx;
  logic [IW-1:0] b_head, r_head;
  logic [CW-1:0] b_count, r_count;
  logic          b_full, b_empty, r_full, r_empty;
  logic          b_pop, r_pop;

  always_comb begin
    aw_idx = '0;
    ar_idx = '0;
    for (int i = 0; i < N_IN_PORT; i++) begin
      if (aw_grant[i]) aw_idx = IW'(i);
      if (ar_grant[i]) ar_idx = IW'(i);
    end
  end

  oursring_ostd_fifo #(.DEPTH(OSTD_DEPTH), .W(IW)) u_b_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (|aw_grant),
    .push_idx (aw_idx),
    .pop      (b_pop),
    .head     (b_head),
    .count    (b_count),
    .full     (b_full),
    .empty    (b_empty)
  );

  oursring_ostd_fifo #(.DEPTH(OSTD_DEPTH), .W(IW)) u_r_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (|ar_grant),
    .push_idx (ar_idx),
    .pop      (r_pop),
    .head     (r_head),
    .count    (r_count),
    .full     (r_full),
    .empty    (r_empty)
  );

  assign aw_stall = rstn & b_full;
  assign ar_stall = rstn & r_full;

  // Nothing is routed while rstn is low, so the reset cycle never completes a response.
  always_comb begin
    i_bvalid = '0;
    i_rvalid = '0;
    o_bready = 1'b0;
    o_rready = 1'b0;
    if (rstn) begin
      if (!b_empty) begin
        i_bvalid[b_head] = o_bvalid;
        o_bready         = i_bready[b_head];
      end
`ifdef OURSRING_RESP_ROUTER_ORPHAN_DROP_EN
      else begin
        o_bready = 1'b1;
      end
`endif
      if (!r_empty) begin
        i_rvalid[r_head] = o_rvalid;
        o_rready         = i_rready[r_head];
      end
`ifdef OURSRING_RESP_ROUTER_ORPHAN_DROP_EN
      else begin
        o_rready = 1'b1;
      end
`endif
    end
  end

  assign b_pop = o_bvalid & o_bready & ~b_empty;
  assign r_pop = o_rvalid & o_rready & o_rlast & ~r_empty;

`ifdef OURSRING_RESP_ROUTER_ORPHAN_DROP_EN
  // An orphan R burst counts once, on its last beat.
  logic       orph_b, orph_r;
  logic [8:0] orph_sum;

  assign orph_b   = rstn & b_empty & o_bvalid;
  assign orph_r   = rstn & r_empty & o_rvalid & o_rlast;
  assign orph_sum = {1'b0, orphan_cnt} + {8'd0, orph_b} + {8'd0, orph_r};

  always_ff @(posedge clk) begin
    if (!rstn) orphan_cnt <= '0;
    else       orphan_cnt <= orph_sum[8] ? 8'hFF : orph_sum[7:0];
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rstn) begin
      assert ($onehot0(aw_grant)) else $error("aw_grant not one-hot: %b", aw_grant);
      assert ($onehot0(ar_grant)) else $error("ar_grant not one-hot: %b", ar_grant);
      assert ($onehot0(i_bvalid)) else $error("i_bvalid not one-hot: %b", i_bvalid);
      assert ($onehot0(i_rvalid)) else $error("i_rvalid not one-hot: %b", i_rvalid);
      assert (b_count <= CW'(OSTD_DEPTH) && r_count <= CW'(OSTD_DEPTH))
        else $error("order FIFO count overflow");
      assert (!(aw_stall && |aw_grant)) else $warning("aw grant while stalled was dropped");
      assert (!(ar_stall && |ar_grant)) else $warning("ar grant while stalled was dropped");
    end
  end
`endif

endmodule

// File: doc/oursring_resp_router.md
OURSRING_RESP_ROUTER -- requirements
Module: oursring_resp_router

Interface
REQ-001 The block SHALL take parameter N_IN_PORT, default 3, number of master ports.
REQ-002 The block SHALL take parameter OSTD_DEPTH, default 4, number of outstanding transactions tracked per channel (power of two, 2..16).
REQ-003 The block SHALL have these ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- aw_grant  in  N_IN_PORT  one-hot AW handshake done this cycle, per master (awvalid & awready).
- ar_grant  in  N_IN_PORT  one-hot AR handshake done this cycle, per master.
- aw_stall  out  1  B order FIFO full; request arbiter SHALL not grant AW.
- ar_stall  out  1  R order FIFO full; request arbiter SHALL not grant AR.
- o_bvalid  in  1  downstream B valid.
- o_bready  out  1  downstream B ready.
- o_rvalid  in  1  downstream R valid.
- o_rlast  in  1  last beat of R burst.
- o_rready  out  1  downstream R ready.
- i_bvalid  out  N_IN_PORT  B valid to each master.
- i_bready  in  N_IN_PORT  B ready from each master.
- i_rvalid  out  N_IN_PORT  R valid to each master.
- i_rready  in  N_IN_PORT  R ready from each master.
REQ-004 Payload (id, resp, data) SHALL bypass the block and be broadcast; only handshakes are routed.

Function
REQ-005 Each aw_grant handshake SHALL push the granted port index into the B order FIFO; each ar_grant handshake SHALL push it into the R order FIFO.
REQ-006 Downstream responses SHALL be in issue order per channel; the FIFO head SHALL select the destination port.
REQ-007 B routing: when B FIFO non-empty, i_bvalid[head] = o_bvalid, o_bready = i_bready[head], all other bits 0; purely combinational, zero latency.
REQ-008 B FIFO SHALL pop on o_bvalid & o_bready.
REQ-009 R routing: same as B using R FIFO head; burst beats stay on the head port; pop only on o_rvalid & o_rready & o_rlast.
REQ-010 Push and pop in the same cycle SHALL both take effect; occupancy unchanged; on a full FIFO, a same-cycle pop SHALL not permit a push (stall decided from registered count).
REQ-011 aw_stall SHALL equal (count_b == OSTD_DEPTH); ar_stall SHALL equal (count_r == OSTD_DEPTH); a push while stall is high SHALL be ignored and flagged by assertion.
REQ-012 Pointers SHALL wrap modulo OSTD_DEPTH; count width SHALL be $clog2(OSTD_DEPTH)+1.
REQ-013 Empty FIFO, no macro: o_bready/o_rready SHALL be 0 and all i_bvalid/i_rvalid 0.
REQ-014 A push into an empty FIFO SHALL become visible as the head on the next cycle (1-cycle latency, no bypass).
REQ-015 Non-synthesis assertions SHALL check grant inputs one-hot-or-zero and i_bvalid/i_rvalid one-hot-or-zero.

Reset
REQ-016 On rstn low at clk edge: pointers and counts 0, both FIFOs empty, aw_stall=0, ar_stall=0, o_bready=0, o_rready=0, i_bvalid=0, i_rvalid=0.
REQ-017 Reset mid-burst SHALL discard all outstanding entries; no response SHALL be routed in the reset cycle.

Configuration
REQ-018 Macro OURSRING_RESP_ROUTER_ORPHAN_DROP_EN defined: a response arriving with its FIFO empty SHALL be accepted (o_bready/o_rready=1), delivered to no port, and counted in output orphan_cnt (8 bits, saturating, reset 0).
REQ-019 Macro undefined: orphan_cnt port absent; REQ-013 behaviour applies (orphan stalls).

Structure
REQ-020 Shared package oursring_pkg SHALL hold the OSTD_DEPTH default and the port-index typedef width rule.
REQ-021 Sub-module oursring_ostd_fifo (index FIFO, push/pop/head/count) SHALL be instanced twice, B and R.

Verification
REQ-022 aw_grant=3'b010, then o_bvalid with i_bready[1]=1 -> i_bvalid=3'b010 one cycle after grant, FIFO empty after handshake.
REQ-023 ar_grant 3'b001 then 3'b100; 4-beat R burst then 2-beat -> beats 1-4 on port 0, beats 5-6 on port 2, pop only on rlast.
REQ-024 Four AW grants, OSTD_DEPTH=4 -> aw_stall=1 next cycle; pop plus attempted push same cycle -> count 3, aw_stall=0.
REQ-025 i_rready[head]=0 mid-burst -> o_rready=0, head unchanged, no beat lost.
REQ-026 Reset asserted with 2 outstanding R -> all outputs 0, counts 0; with macro, subsequent orphan o_bvalid -> o_bready=1, orphan_cnt=1.
